hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage core. It sequences the execute stage: register-operand forwarding selects for the EX operand muxes, load-use stalls, branch/jump flushes driven by the EX branch-resolve output, and a multi-cycle stall FSM for long-latency EX ops (mul/div).
- Sits beside the pipeline registers. Drives their stall/flush enables and the EX forwarding muxes.
- Also keeps saturating stall/flush performance counters.

---
 rtl/core_pkg.sv | 20 ++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core's pipeline control logic.
package core_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_MULTI = 1'b1
  } hz_state_t;

  localparam int REG_X0 = 0;

  // Wide enough for MC_LATENCY-2 at the maximum legal latency of 16.
  localparam int MC_CNT_WIDTH = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with a synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard control: operand forwarding, load-use stall,
// branch flush, multi-cycle EX stall sequencing and stall/flush counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LATENCY     = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      LoadE,
  input  logic                      MultiCycleE,
  input  logic                      PCSrcE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
  output logic                      McDoneE,
  output logic [CNT_WIDTH-1:0]      StallCount,
  output logic [CNT_WIDTH-1:0]      FlushCount,
  output hz_state_t                 dbg_state
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(REG_X0);
  localparam logic [MC_CNT_WIDTH-1:0] MC_INIT =
    MC_CNT_WIDTH'((MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0);

  hz_state_t               state_q, state_d;
  logic [MC_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    mc_stall, mc_done, lw_stall, br_flush;
  fwd_sel_t                fwd_a, fwd_b;

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The triggering RUN cycle is the first stall, so MULTI only counts the
  // remaining MC_LATENCY-2 stalls before the done cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    mc_done  = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (MultiCycleE) begin
          if (MC_LATENCY > 1) begin
            mc_stall = 1'b1;
            cnt_d    = MC_INIT;
            state_d  = HZ_MULTI;
          end else begin
            mc_done = 1'b1;
          end
        end
      end
      HZ_MULTI: begin
        if (cnt_q != '0) begin
          mc_stall = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else begin
          mc_done = 1'b1;
          state_d = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (RegWriteM && (RdM != X0) && (RdM == Rs1E))      fwd_a = FWD_MEM;
    else if (RegWriteW && (RdW != X0) && (RdW == Rs1E)) fwd_a = FWD_WB;
    if (RegWriteM && (RdM != X0) && (RdM == Rs2E))      fwd_b = FWD_MEM;
    else if (RegWriteW && (RdW != X0) && (RdW == Rs2E)) fwd_b = FWD_WB;
  end

  assign lw_stall = LoadE && (RdE != X0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign br_flush = PCSrcE && !mc_stall;

  // While in reset the pipeline registers are all bubbled and nothing stalls.
  always_comb begin
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushM    = 1'b1;
    McDoneE   = 1'b0;
    if (rst_n) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = lw_stall || mc_stall;
      StallD    = lw_stall || mc_stall;
      StallE    = mc_stall;
      FlushD    = br_flush;
      FlushE    = !mc_stall && (lw_stall || PCSrcE);
      FlushM    = mc_stall;
      McDoneE   = mc_done;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (StallF),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (FlushD),
    .count (FlushCount)
  );

endmodule
